// File: rtl/cuckoo_pkg.sv
// Shared definitions for the two-table cuckoo hash store: response status
// codes, FSM state encodings and the h1/h2 index hash functions.
package cuckoo_pkg;

  // Golden-ratio multiplier used by the h2 multiplicative hash
  localparam logic [31:0] HASH_MUL = 32'h9E3779B1;

  // Response status encodings
  localparam logic [1:0] STAT_OK        = 2'b00;
  localparam logic [1:0] STAT_FOUND     = 2'b01;
  localparam logic [1:0] STAT_NOT_FOUND = 2'b10;
  localparam logic [1:0] STAT_FAIL      = 2'b11;

  // Controller FSM state encodings
  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHK   = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;
  localparam logic [1:0] S_RSP   = 2'd3;

  // h1: XOR-fold of the key in idx_w-bit chunks (keys up to 64 bits,
  // indices up to 16 bits; the caller truncates to its own index width)
  function automatic logic [15:0] h1_fold(input logic [63:0] k,
                                          input int key_w,
                                          input int idx_w);
    logic [15:0] mask;
    logic [15:0] acc;
    mask = 16'((17'd1 << idx_w) - 17'd1);
    acc  = 16'd0;
    for (int i = 0; i < 64; i++) begin
      if ((i * idx_w) < key_w) begin
        acc = acc ^ (16'(k >> (i * idx_w)) & mask);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // h2: top idx_w bits of (k * HASH_MUL) mod 2**key_w
  function automatic logic [15:0] h2_mul(input logic [63:0] k,
                                         input int key_w,
                                         input int idx_w);
    logic [63:0] prod;
    prod = k * {32'h0000_0000, HASH_MUL};
    if (key_w < 64) begin
      prod = prod & ((64'd1 << key_w) - 64'd1);
    end else begin
      prod = prod;
    end
    return 16'((prod >> (key_w - idx_w)) & ((64'd1 << idx_w) - 64'd1));
  endfunction

endpackage

// File: rtl/cuckoo_insert_ctrl_if.sv
// Request/response bundle between a key-value requester and the cuckoo
// insert controller. The requester uses the master view, the controller
// the slave view.
interface cuckoo_insert_ctrl_if #(
  parameter int KEY_W = 32,
  parameter int IDX_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic               req_op;
  logic [KEY_W-1:0]   req_key;
  logic               rsp_valid;
  logic [1:0]         rsp_status;
  logic [IDX_W:0]     rsp_pos;
  logic [KEY_W-1:0]   rsp_key;
  logic [IDX_W+1:0]   occ_count;

  modport master (
    output req_valid, req_op, req_key,
    input  req_ready, rsp_valid, rsp_status, rsp_pos, rsp_key, occ_count
  );

  modport slave (
    input  req_valid, req_op, req_key,
    output req_ready, rsp_valid, rsp_status, rsp_pos, rsp_key, occ_count
  );
endinterface

// File: rtl/cuckoo_table.sv
// One cuckoo hash table: 2**IDX_W key slots with valid bits.
// Combinational read, single synchronous write port; reset empties it.
module cuckoo_table #(
  parameter int KEY_W = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key
);
  localparam int DEPTH = 1 << IDX_W;

  logic [KEY_W-1:0] key_mem_r [DEPTH];
  logic [DEPTH-1:0] vld_r;

  assign rd_key   = key_mem_r[rd_idx];
  assign rd_valid = vld_r[rd_idx];

  // Slot storage: reset clears every slot, otherwise a write fills one slot
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        key_mem_r[i] <= {KEY_W{1'b0}};
      end
    end else if (wr_en) begin
      vld_r[wr_idx]     <= 1'b1;
      key_mem_r[wr_idx] <= wr_key;
    end else begin
      vld_r <= vld_r;
    end
  end

endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Sequencing controller for the two-table cuckoo hash store. Accepts one
// lookup/insert at a time, runs the duplicate check, then a bounded
// kick-out chain (one table access per cycle), and returns a one-cycle
// status pulse. It is the only writer of the two tables.
module cuckoo_insert_ctrl
  import cuckoo_pkg::*;
#(
  parameter int KEY_W     = 32,
  parameter int IDX_W     = 4,
  parameter int MAX_KICKS = 20
) (
  input logic                clk,
  input logic                rst,
  cuckoo_insert_ctrl_if.slave bus
);
  localparam int KICK_W = $clog2(MAX_KICKS + 1);
  localparam int POS_W  = IDX_W + 1;
  localparam int OCC_W  = IDX_W + 2;
  localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(MAX_KICKS);

  // Registered state
  state_t             state_r;
  logic               op_r;
  logic [KEY_W-1:0]   cur_r;
  logic               tbl_r;
  logic [KICK_W-1:0]  kicks_r;
  logic [OCC_W-1:0]   occ_r;
  logic               req_ready_r;
  logic               rsp_valid_r;
  logic [1:0]         rsp_status_r;
  logic [POS_W-1:0]   rsp_pos_r;
  logic [KEY_W-1:0]   rsp_key_r;

  // Next-state values
  state_t             state_nx;
  logic               op_nx;
  logic [KEY_W-1:0]   cur_nx;
  logic               tbl_nx;
  logic [KICK_W-1:0]  kicks_nx;
  logic [OCC_W-1:0]   occ_nx;
  logic               rsp_valid_nx;
  logic [1:0]         rsp_status_nx;
  logic [POS_W-1:0]   rsp_pos_nx;
  logic [KEY_W-1:0]   rsp_key_nx;

  // Table access
  logic [IDX_W-1:0]   h1_cur_s;
  logic [IDX_W-1:0]   h2_cur_s;
  logic [KEY_W-1:0]   t1_key_s;
  logic [KEY_W-1:0]   t2_key_s;
  logic               t1_vld_s;
  logic               t2_vld_s;
  logic               t1_we_s;
  logic               t2_we_s;
  logic               t1_hit_s;
  logic               t2_hit_s;
  logic [IDX_W-1:0]   place_idx_s;
  logic [KEY_W-1:0]   place_key_s;
  logic               place_vld_s;
  logic [KICK_W-1:0]  kicks_inc_s;

  // Both tables are always addressed by the hashes of cur; in CHK cur holds
  // the request key, in PLACE it holds the key currently being placed.
  assign h1_cur_s = IDX_W'(h1_fold(64'(cur_r), KEY_W, IDX_W));
  assign h2_cur_s = IDX_W'(h2_mul(64'(cur_r), KEY_W, IDX_W));

  assign t1_hit_s = t1_vld_s && (t1_key_s == cur_r);
  assign t2_hit_s = t2_vld_s && (t2_key_s == cur_r);

  assign place_idx_s = tbl_r ? h2_cur_s : h1_cur_s;
  assign place_key_s = tbl_r ? t2_key_s : t1_key_s;
  assign place_vld_s = tbl_r ? t2_vld_s : t1_vld_s;
  assign kicks_inc_s = kicks_r + KICK_W'(1);

  cuckoo_table #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_t1 (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (h1_cur_s),
    .rd_key   (t1_key_s),
    .rd_valid (t1_vld_s),
    .wr_en    (t1_we_s),
    .wr_idx   (h1_cur_s),
    .wr_key   (cur_r)
  );

  cuckoo_table #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_t2 (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (h2_cur_s),
    .rd_key   (t2_key_s),
    .rd_valid (t2_vld_s),
    .wr_en    (t2_we_s),
    .wr_idx   (h2_cur_s),
    .wr_key   (cur_r)
  );

  // FSM next-state, table write enables and response construction
  always_comb begin
    state_nx      = state_r;
    op_nx         = op_r;
    cur_nx        = cur_r;
    tbl_nx        = tbl_r;
    kicks_nx      = kicks_r;
    occ_nx        = occ_r;
    rsp_valid_nx  = 1'b0;
    rsp_status_nx = rsp_status_r;
    rsp_pos_nx    = rsp_pos_r;
    rsp_key_nx    = rsp_key_r;
    t1_we_s       = 1'b0;
    t2_we_s       = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_nx    = bus.req_op;
          cur_nx   = bus.req_key;
          tbl_nx   = 1'b0;
          kicks_nx = {KICK_W{1'b0}};
          state_nx = S_CHK;
        end else begin
          state_nx = S_IDLE;
        end
      end

      S_CHK: begin
        if (t1_hit_s) begin
          rsp_status_nx = STAT_FOUND;
          rsp_pos_nx    = {1'b0, h1_cur_s};
          rsp_key_nx    = {KEY_W{1'b0}};
          rsp_valid_nx  = 1'b1;
          state_nx      = S_RSP;
        end else if (t2_hit_s) begin
          rsp_status_nx = STAT_FOUND;
          rsp_pos_nx    = {1'b1, h2_cur_s};
          rsp_key_nx    = {KEY_W{1'b0}};
          rsp_valid_nx  = 1'b1;
          state_nx      = S_RSP;
        end else if (!op_r) begin
          rsp_status_nx = STAT_NOT_FOUND;
          rsp_pos_nx    = {POS_W{1'b0}};
          rsp_key_nx    = {KEY_W{1'b0}};
          rsp_valid_nx  = 1'b1;
          state_nx      = S_RSP;
        end else begin
          state_nx = S_PLACE;
        end
      end

      S_PLACE: begin
        // cur is written into the addressed slot whether or not it is full
        t1_we_s = ~tbl_r;
        t2_we_s = tbl_r;
        if (!place_vld_s) begin
          occ_nx        = occ_r + OCC_W'(1);
          rsp_status_nx = STAT_OK;
          rsp_pos_nx    = {tbl_r, place_idx_s};
          rsp_key_nx    = {KEY_W{1'b0}};
          rsp_valid_nx  = 1'b1;
          state_nx      = S_RSP;
        end else begin
          cur_nx   = place_key_s;
          tbl_nx   = ~tbl_r;
          kicks_nx = kicks_inc_s;
          if (kicks_inc_s == KICK_LAST) begin
            // The evicted occupant is left without a home
            rsp_status_nx = STAT_FAIL;
            rsp_pos_nx    = {tbl_r, place_idx_s};
            rsp_key_nx    = place_key_s;
            rsp_valid_nx  = 1'b1;
            state_nx      = S_RSP;
          end else begin
            state_nx = S_PLACE;
          end
        end
      end

      S_RSP: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any chain in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= 1'b0;
      cur_r        <= {KEY_W{1'b0}};
      tbl_r        <= 1'b0;
      kicks_r      <= {KICK_W{1'b0}};
      occ_r        <= {OCC_W{1'b0}};
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= 2'b00;
      rsp_pos_r    <= {POS_W{1'b0}};
      rsp_key_r    <= {KEY_W{1'b0}};
    end else begin
      state_r      <= state_nx;
      op_r         <= op_nx;
      cur_r        <= cur_nx;
      tbl_r        <= tbl_nx;
      kicks_r      <= kicks_nx;
      occ_r        <= occ_nx;
      req_ready_r  <= (state_nx == S_IDLE);
      rsp_valid_r  <= rsp_valid_nx;
      rsp_status_r <= rsp_status_nx;
      rsp_pos_r    <= rsp_pos_nx;
      rsp_key_r    <= rsp_key_nx;
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_status = rsp_status_r;
  assign bus.rsp_pos    = rsp_pos_r;
  assign bus.rsp_key    = rsp_key_r;
  assign bus.occ_count  = occ_r;

endmodule
